// File: rtl/tlul_cmd_intg_chk_mc.sv
// Multi-channel TL-UL A-channel command-integrity checker with sticky flags,
// saturating per-channel error counters and a 4-phase alert handshake.

package tlul_pkg;
    localparam int H2DCmdMaxWidth = 57;

    typedef logic [3:0] mubi4_t;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        mubi4_t     instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        mubi4_t      instr_type;
        logic [31:0] addr;
        tl_a_op_e    opcode;
        logic [3:0]  mask;
    } tl_h2d_cmd_intg_t;

    function automatic tl_h2d_cmd_intg_t extract_h2d_cmd_intg(tl_h2d_t tl);
        tl_h2d_cmd_intg_t payload;
        payload.instr_type = tl.a_user.instr_type;
        payload.addr       = tl.a_address;
        payload.opcode     = tl.a_opcode;
        payload.mask       = tl.a_mask;
        return payload;
    endfunction
endpackage

// Hsiao (64,57) SECDED decoder: 57 data bits in [56:0], check bits in [63:57].
module prim_secded_64_57_dec (
    input  logic [63:0] data_i,
    output logic [56:0] data_o,
    output logic [6:0]  syndrome_o,
    output logic [1:0]  err_o
);
    localparam logic [6:0][63:0] SynMask = {
        64'h81FBDDA769A46910, 64'h41F7BB56D5525488, 64'h21EF76CDB2C93244,
        64'h11DEEE3B8E388E22, 64'h09BDE1F87E0781E1, 64'h057C1FF801FF801F,
        64'h0303FFF800007FFF
    };

    logic [6:0] col;

    always_comb begin
        syndrome_o = '0;
        col        = '0;
        data_o     = data_i[56:0];
        for (int i = 0; i < 7; i++) begin
            syndrome_o[i] = ^(data_i & SynMask[i]);
        end
        // A single-bit error flips the data bit whose column matches the syndrome.
        for (int b = 0; b < 57; b++) begin
            for (int i = 0; i < 7; i++) begin
                col[i] = SynMask[i][b];
            end
            data_o[b] = data_i[b] ^ (syndrome_o == col);
        end
        err_o[0] = ^syndrome_o;
        err_o[1] = ~(^syndrome_o) & (|syndrome_o);
    end
endmodule

module tlul_cmd_intg_chk_mc
    import tlul_pkg::*;
#(
    parameter int NumCh    = 2,
    parameter bit Pipeline = 1'b1,
    parameter int ErrCntW  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  tl_h2d_t [NumCh-1:0]        tl_i,
    input  logic [NumCh-1:0]           a_ready_i,
    input  logic [NumCh-1:0]           clr_i,
    output logic [NumCh-1:0]           err_o,
    output logic [NumCh-1:0]           err_sticky_o,
    output logic [NumCh*ErrCntW-1:0]   err_cnt_o,
    output logic                       alert_req_o,
    input  logic                       alert_ack_i
);
    if ($bits(tl_h2d_cmd_intg_t) > H2DCmdMaxWidth) begin : gen_width_chk
        $fatal(1, "command integrity payload wider than H2DCmdMaxWidth");
    end
    if (NumCh < 1 || NumCh > 16) begin : gen_numch_chk
        $fatal(1, "NumCh must be in 1..16");
    end
    if (ErrCntW < 2 || ErrCntW > 16) begin : gen_cntw_chk
        $fatal(1, "ErrCntW must be in 2..16");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StWaitLo = 2'd2
    } alert_st_e;

    logic [NumCh-1:0][63:0]          dec_in;
    logic [NumCh-1:0][56:0]          dec_data;
    logic [NumCh-1:0][6:0]           dec_syn;
    logic [NumCh-1:0][1:0]           dec_err;
    logic [NumCh-1:0]                raw;
    logic [NumCh-1:0]                acc;
    logic [NumCh-1:0]                unused_ch;
    logic                            unused_tl;
    logic                            new_err;

    logic [NumCh-1:0][ErrCntW-1:0]   cnt_q, cnt_d, cnt_base;
    logic [NumCh-1:0]                sticky_q, sticky_d;
    alert_st_e                       state_q;
    logic                            pending_q;
    logic                            alert_req_q;

    for (genvar c = 0; c < NumCh; c++) begin : gen_ch
        assign dec_in[c] = {tl_i[c].a_user.cmd_intg,
                            H2DCmdMaxWidth'(extract_h2d_cmd_intg(tl_i[c]))};

        prim_secded_64_57_dec u_dec (
            .data_i     (dec_in[c]),
            .data_o     (dec_data[c]),
            .syndrome_o (dec_syn[c]),
            .err_o      (dec_err[c])
        );

        assign raw[c] = tl_i[c].a_valid & (|dec_err[c]);
        assign acc[c] = raw[c] & a_ready_i[c];

        assign unused_ch[c] = ^{tl_i[c].a_param, tl_i[c].a_size, tl_i[c].a_source,
                                tl_i[c].a_data, tl_i[c].a_user.rsvd,
                                tl_i[c].a_user.data_intg, tl_i[c].d_ready,
                                dec_data[c], dec_syn[c]};
    end

    assign unused_tl = ^unused_ch;
    assign new_err   = |acc;

    if (Pipeline) begin : gen_pipe
        logic [NumCh-1:0] err_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                err_q <= '0;
            end else begin
                err_q <= raw;
            end
        end
        assign err_o = err_q;
    end else begin : gen_comb
        assign err_o = raw;
    end

    // Clear applies before the increment, so clear+error in one cycle lands on 1.
    always_comb begin
        cnt_base = '0;
        cnt_d    = '0;
        for (int c = 0; c < NumCh; c++) begin
            cnt_base[c] = clr_i[c] ? '0 : cnt_q[c];
            cnt_d[c]    = (acc[c] && (cnt_base[c] != {ErrCntW{1'b1}}))
                          ? cnt_base[c] + ErrCntW'(1) : cnt_base[c];
        end
    end

    assign sticky_d = acc | (sticky_q & ~clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            sticky_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    // Errors arriving mid-handshake collapse into one pending follow-up alert.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            alert_req_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (new_err || pending_q) begin
                        state_q     <= StReq;
                        pending_q   <= 1'b0;
                        alert_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (new_err) begin
                        pending_q <= 1'b1;
                    end
                    if (alert_ack_i) begin
                        state_q     <= StWaitLo;
                        alert_req_q <= 1'b0;
                    end
                end
                StWaitLo: begin
                    if (new_err) begin
                        pending_q <= 1'b1;
                    end
                    if (!alert_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    alert_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;
    assign alert_req_o  = alert_req_q;
endmodule

// File: tb/tb_tlul_cmd_intg_chk_mc.sv
// Bench for tlul_cmd_intg_chk_mc: one stimulus drives a registered 8-bit-counter
// instance and a combinational 2-bit-counter instance, both checked against a model.
module tb_tlul_cmd_intg_chk_mc;
    import tlul_pkg::*;

    localparam int NumCh = 2;

    // Check-bit generation rule of the (64,57) code.
    localparam logic [6:0][63:0] EncMask = {
        64'h01FBDDA769A46910, 64'h01F7BB56D5525488, 64'h01EF76CDB2C93244,
        64'h01DEEE3B8E388E22, 64'h01BDE1F87E0781E1, 64'h017C1FF801FF801F,
        64'h0103FFF800007FFF
    };

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    tl_h2d_t [NumCh-1:0]  tl;
    logic [NumCh-1:0]     a_ready;
    logic [NumCh-1:0]     clr;
    logic                 ack;

    logic [NumCh-1:0]     err_a, err_b, sticky_a, sticky_b;
    logic [15:0]          cnt_a;
    logic [3:0]           cnt_b;
    logic                 req_a, req_b;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;

    always #5 clk = ~clk;

    tlul_cmd_intg_chk_mc #(.NumCh(NumCh), .Pipeline(1'b1), .ErrCntW(8)) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_i         (tl),
        .a_ready_i    (a_ready),
        .clr_i        (clr),
        .err_o        (err_a),
        .err_sticky_o (sticky_a),
        .err_cnt_o    (cnt_a),
        .alert_req_o  (req_a),
        .alert_ack_i  (ack)
    );

    tlul_cmd_intg_chk_mc #(.NumCh(NumCh), .Pipeline(1'b0), .ErrCntW(2)) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_i         (tl),
        .a_ready_i    (a_ready),
        .clr_i        (clr),
        .err_o        (err_b),
        .err_sticky_o (sticky_b),
        .err_cnt_o    (cnt_b),
        .alert_req_o  (req_b),
        .alert_ack_i  (ack)
    );

    always @(posedge req_a) rises++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] cmd_ecc(input tl_h2d_t t);
        logic [63:0] p;
        logic [6:0]  e;
        p = {7'b0, 14'b0, t.a_user.instr_type, t.a_address, t.a_opcode, t.a_mask};
        for (int i = 0; i < 7; i++) e[i] = ^(p & EncMask[i]);
        return e;
    endfunction

    function automatic bit is_bad(input tl_h2d_t t);
        return t.a_valid && (t.a_user.cmd_intg != cmd_ecc(t));
    endfunction

    function automatic tl_h2d_t mk_good(input logic [31:0] addr, input tl_a_op_e op,
                                        input logic [3:0] mask);
        tl_h2d_t t;
        t = '0;
        t.a_valid             = 1'b1;
        t.a_opcode            = op;
        t.a_address           = addr;
        t.a_mask              = mask;
        t.a_size              = 2'd2;
        t.a_source            = 8'($urandom_range(0, 255));
        t.a_data              = $urandom;
        t.a_user.instr_type   = 4'h9;
        t.a_user.data_intg    = 7'($urandom_range(0, 127));
        t.d_ready             = 1'b1;
        t.a_user.cmd_intg     = cmd_ecc(t);
        return t;
    endfunction

    function automatic tl_h2d_t mk_bad_addr(input logic [31:0] addr);
        tl_h2d_t t;
        t = mk_good(addr, PutFullData, 4'hF);
        t.a_address[3] = ~t.a_address[3];
        return t;
    endfunction

    task automatic idle_all();
        tl      = '0;
        a_ready = '0;
        clr     = '0;
    endtask

    // Reference model: state advances at each rising edge from the inputs seen there.
    bit m_err_q [NumCh];
    int m_cnt_a [NumCh];
    int m_cnt_b [NumCh];
    bit m_sticky[NumCh];
    bit m_req, m_wait, m_pend;

    always @(posedge clk) begin : model_cmp
        bit raw_m, acc_m, any_m;
        if (rst) begin
            for (int c = 0; c < NumCh; c++) begin
                m_err_q[c] = 0; m_cnt_a[c] = 0; m_cnt_b[c] = 0; m_sticky[c] = 0;
            end
            m_req = 0; m_wait = 0; m_pend = 0;
        end else begin
            any_m = 0;
            for (int c = 0; c < NumCh; c++) begin
                raw_m = is_bad(tl[c]);
                acc_m = raw_m && a_ready[c];
                any_m = any_m || acc_m;
                m_err_q[c] = raw_m;
                m_cnt_a[c] = (clr[c] ? 0 : m_cnt_a[c]) + int'(acc_m);
                if (m_cnt_a[c] > 255) m_cnt_a[c] = 255;
                m_cnt_b[c] = (clr[c] ? 0 : m_cnt_b[c]) + int'(acc_m);
                if (m_cnt_b[c] > 3) m_cnt_b[c] = 3;
                m_sticky[c] = acc_m || (m_sticky[c] && !clr[c]);
            end
            if (!m_req && !m_wait) begin
                if (any_m || m_pend) begin
                    m_req  = 1;
                    m_pend = 0;
                end
            end else begin
                if (any_m) m_pend = 1;
                if (m_req && ack) begin
                    m_req  = 0;
                    m_wait = 1;
                end else if (m_wait && !ack) begin
                    m_wait = 0;
                end
            end
        end
        #1;
        for (int c = 0; c < NumCh; c++) begin
            check($sformatf("err_a[%0d]", c), 32'(err_a[c]), 32'(m_err_q[c]));
            check($sformatf("err_b[%0d]", c), 32'(err_b[c]), 32'(is_bad(tl[c])));
            check($sformatf("sticky_a[%0d]", c), 32'(sticky_a[c]), 32'(m_sticky[c]));
            check($sformatf("sticky_b[%0d]", c), 32'(sticky_b[c]), 32'(m_sticky[c]));
            check($sformatf("cnt_a[%0d]", c), 32'(cnt_a[c*8 +: 8]), 32'(m_cnt_a[c]));
            check($sformatf("cnt_b[%0d]", c), 32'(cnt_b[c*2 +: 2]), 32'(m_cnt_b[c]));
        end
        check("req_a", 32'(req_a), 32'(m_req));
        check("req_b", 32'(req_b), 32'(m_req));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tl_h2d_t t;
        int      r0;
        idle_all();
        ack = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_err_a", 32'(err_a), 0);
        check("rst_sticky", 32'({sticky_a, sticky_b}), 0);
        check("rst_cnt_a", 32'(cnt_a), 0);
        check("rst_cnt_b", 32'(cnt_b), 0);
        check("rst_req", 32'({req_a, req_b}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Clean Get on ch0 accepted for 3 cycles.
        tl[0] = mk_good(32'h0000_1000, Get, 4'hF);
        a_ready[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("s1_err_a", 32'(err_a), 0);
            check("s1_err_b", 32'(err_b), 0);
            check("s1_req", 32'(req_a), 0);
        end
        check("s1_cnt", 32'(cnt_a), 0);
        idle_all();

        // Corrupted address on ch1, stalled 3 cycles, accepted on the 4th.
        t = mk_bad_addr(32'h2000_0040);
        tl[1] = t;
        #1;
        check("s2_err_b_c0", 32'(err_b[1]), 1);
        check("s2_err_a_c0", 32'(err_a[1]), 0);
        @(negedge clk);
        check("s2_err_a_c1", 32'(err_a[1]), 1);
        check("s2_cnt_c1", 32'(cnt_a[15:8]), 0);
        @(negedge clk);
        @(negedge clk);
        check("s2_sticky_c3", 32'(sticky_a[1]), 0);
        a_ready[1] = 1'b1;
        @(negedge clk);
        idle_all();
        check("s2_err_a_c4", 32'(err_a[1]), 1);
        check("s2_cnt_a_c4", 32'(cnt_a[15:8]), 1);
        check("s2_cnt_b_c4", 32'(cnt_b[3:2]), 1);
        check("s2_sticky_c4", 32'({sticky_a[1], sticky_b[1]}), 32'h3);
        check("s2_req_c4", 32'(req_a), 1);
        @(negedge clk);
        check("s2_err_a_c5", 32'(err_a[1]), 0);
        check("s2_req_c5", 32'(req_a), 1);
        ack = 1'b1;
        @(negedge clk);
        check("s2_req_acked", 32'(req_a), 0);
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);

        // Second accepted error during WAIT_LO yields exactly one extra alert.
        r0 = rises;
        tl[0] = mk_bad_addr(32'h0000_3000);
        a_ready[0] = 1'b1;
        @(negedge clk);
        idle_all();
        check("s3_req_up", 32'(req_a), 1);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        check("s3_req_low", 32'(req_a), 0);
        tl[1] = mk_bad_addr(32'h0000_4400);
        a_ready[1] = 1'b1;
        @(negedge clk);
        idle_all();
        ack = 1'b0;
        @(negedge clk);
        check("s3_idle_gap", 32'(req_a), 0);
        @(negedge clk);
        check("s3_req_again", 32'(req_a), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("s3_req_drop2", 32'(req_a), 0);
        repeat (5) @(negedge clk);
        check("s3_rises", 32'(rises - r0), 2);
        check("s3_req_final", 32'(req_a), 0);

        // Saturation on the 2-bit counter, then clear with and without a new error.
        clr = 2'b11;
        @(negedge clk);
        clr = 2'b00;
        check("s4_cleared", 32'({cnt_a, cnt_b}), 0);
        for (int k = 0; k < 5; k++) begin
            tl[0] = mk_bad_addr(32'($urandom_range(0, 4095)) << 4);
            a_ready[0] = 1'b1;
            @(negedge clk);
        end
        check("s4_sat_b", 32'(cnt_b[1:0]), 3);
        check("s4_cnt_a5", 32'(cnt_a[7:0]), 5);
        tl[0] = mk_bad_addr(32'h0000_5000);
        clr[0] = 1'b1;
        @(negedge clk);
        check("s4_clr_err_b", 32'(cnt_b[1:0]), 1);
        check("s4_clr_err_a", 32'(cnt_a[7:0]), 1);
        check("s4_clr_sticky", 32'({sticky_a[0], sticky_b[0]}), 32'h3);
        idle_all();
        clr[0] = 1'b1;
        @(negedge clk);
        clr = 2'b00;
        check("s4_clr_only_b", 32'(cnt_b[1:0]), 0);
        check("s4_clr_only_a", 32'(cnt_a[7:0]), 0);
        check("s4_clr_only_st", 32'({sticky_a[0], sticky_b[0]}), 0);

        // Double-bit flip in cmd_intg on ch1.
        t = mk_good(32'h0000_6000, Get, 4'h3);
        t.a_user.cmd_intg = t.a_user.cmd_intg ^ 7'b000_1001;
        tl[1] = t;
        a_ready[1] = 1'b1;
        #1;
        check("s5_err_b_now", 32'(err_b[1]), 1);
        check("s5_err_a_now", 32'(err_a[1]), 0);
        @(negedge clk);
        check("s5_err_a_next", 32'(err_a[1]), 1);
        check("s5_cnt_b", 32'(cnt_b[3:2]), 1);
        check("s5_sticky_b", 32'(sticky_b[1]), 1);
        clr[1] = 1'b1;
        @(negedge clk);
        check("s5_clr_err_cnt", 32'(cnt_b[3:2]), 1);
        check("s5_clr_err_st", 32'(sticky_b[1]), 1);
        idle_all();
        clr[1] = 1'b1;
        #1;
        check("s5_err_b_gone", 32'(err_b[1]), 0);
        @(negedge clk);
        clr = 2'b00;
        check("s5_clr_only_cnt", 32'(cnt_b[3:2]), 0);
        check("s5_clr_only_st", 32'(sticky_b[1]), 0);

        // Asynchronous reset while the alert is requested with a follow-up pending.
        check("s6_req_before", 32'(req_a), 1);
        r0 = rises;
        #2;
        rst = 1'b1;
        #1;
        check("s6_rst_err", 32'({err_a, err_b}), 0);
        check("s6_rst_sticky", 32'({sticky_a, sticky_b}), 0);
        check("s6_rst_cnt", 32'({cnt_a, cnt_b}), 0);
        check("s6_rst_req", 32'({req_a, req_b}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("s6_no_alert", 32'(rises - r0), 0);
        check("s6_req_idle", 32'(req_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
